// File: rtl/spw_tx_arbiter_if.sv
// Handshake bundle between the packet/time-code sources, the arbiter and the SpaceWire TX core.
// master = arbiter side, slave = source/TX-core side.
interface spw_tx_arbiter_if;
  logic [8:0] src0_data, src1_data;
  logic       src0_valid, src1_valid;
  logic       src0_ready, src1_ready;
  logic [7:0] tc_data;
  logic       tc_valid, tc_ready;
  logic [8:0] data_tx_to_w;
  logic       data_en_to_w, data_tx_ready;
  logic [7:0] timec_tx_to_w;
  logic       timec_en_to_tx, timec_tx_ready;
  logic [1:0] grant;
  logic       timeout_pulse, abort_pulse;

  modport master (
    input  src0_data, src1_data, src0_valid, src1_valid, tc_data, tc_valid,
           data_tx_ready, timec_tx_ready,
    output src0_ready, src1_ready, tc_ready, data_tx_to_w, data_en_to_w,
           timec_tx_to_w, timec_en_to_tx, grant, timeout_pulse, abort_pulse
  );

  modport slave (
    output src0_data, src1_data, src0_valid, src1_valid, tc_data, tc_valid,
           data_tx_ready, timec_tx_ready,
    input  src0_ready, src1_ready, tc_ready, data_tx_to_w, data_en_to_w,
           timec_tx_to_w, timec_en_to_tx, grant, timeout_pulse, abort_pulse
  );
endinterface

// File: rtl/spw_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing one SpaceWire TX between two N-char sources,
// with stall-timeout EEP injection, link-loss discard and an independent time-code path.
module spw_tx_arbiter #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk_clk,
  input  logic reset_reset,
  input  logic link_running,
  spw_tx_arbiter_if.master bus
);
  localparam int            CW     = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);
  localparam logic [CW-1:0] TO_HIT = CW'(TIMEOUT - 1);
  localparam logic [8:0]    EEP    = 9'h101;

  typedef enum logic [1:0] {IDLE, PKT, INJECT, DISCARD} state_t;
  state_t state, state_nxt;

  logic          last_grant;  // 1: src1 owned the previous packet
  logic [CW-1:0] stall_cnt;

  logic [1:0][8:0] src_data;
  logic [1:0]      src_valid, src_ready;
  logic            sel, g_valid, slot_free;
  logic [8:0]      g_data;
  logic            req, pick1, take, load_chr, load_eep, abort, pkt_end;

  assign src_data       = {bus.src1_data, bus.src0_data};
  assign src_valid      = {bus.src1_valid, bus.src0_valid};
  assign bus.src0_ready = src_ready[0];
  assign bus.src1_ready = src_ready[1];

  assign sel       = bus.grant[1];
  assign g_valid   = |(src_valid & bus.grant);
  assign g_data    = src_data[sel];
  assign slot_free = ~bus.data_en_to_w | bus.data_tx_ready;

  assign req   = link_running & (|src_valid);
  assign pick1 = src_valid[1] & (~src_valid[0] | ~last_grant);

  always_ff @(posedge clk_clk) begin
    if (reset_reset) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = PKT;
      PKT: begin
        if (abort)         state_nxt = DISCARD;
        else if (pkt_end)  state_nxt = IDLE;
        else if (load_eep) state_nxt = INJECT;
      end
      INJECT:  if (abort || bus.data_tx_ready) state_nxt = DISCARD;
      DISCARD: if (pkt_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Source readiness is gated by link_running in PKT so no char is consumed in the
  // abort cycle; an end char swallowed there would leave DISCARD waiting forever.
  always_comb begin
    src_ready = '0;
    take      = 1'b0;
    load_chr  = 1'b0;
    load_eep  = 1'b0;
    abort     = 1'b0;
    pkt_end   = 1'b0;
    case (state)
      PKT: begin
        if (!link_running) abort = 1'b1;
        else begin
          src_ready = bus.grant & {2{slot_free}};
          take      = g_valid & slot_free;
          load_chr  = take;
          // Fire on the stall cycle that brings the count to TIMEOUT.
          load_eep  = ~g_valid & slot_free & (stall_cnt >= TO_HIT);
          pkt_end   = take & g_data[8];
        end
      end
      INJECT:  abort = ~link_running;
      DISCARD: begin
        src_ready = bus.grant;
        take      = g_valid;
        pkt_end   = take & g_data[8];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      bus.grant         <= 2'b00;
      last_grant        <= 1'b1;
      stall_cnt         <= '0;
      bus.data_tx_to_w  <= '0;
      bus.data_en_to_w  <= 1'b0;
      bus.timeout_pulse <= 1'b0;
      bus.abort_pulse   <= 1'b0;
    end else begin
      bus.timeout_pulse <= load_eep;
      bus.abort_pulse   <= abort;

      if (state == IDLE && req) bus.grant <= pick1 ? 2'b10 : 2'b01;
      else if (pkt_end) begin
        bus.grant  <= 2'b00;
        last_grant <= sel;
      end

      if (state != PKT || take) stall_cnt <= '0;
      else if (!g_valid && stall_cnt != TO_MAX) stall_cnt <= stall_cnt + 1'b1;

      if (abort) bus.data_en_to_w <= 1'b0;
      else if (load_chr) begin
        bus.data_tx_to_w <= g_data;
        bus.data_en_to_w <= 1'b1;
      end else if (load_eep) begin
        bus.data_tx_to_w <= EEP;
        bus.data_en_to_w <= 1'b1;
      end else if (bus.data_tx_ready) bus.data_en_to_w <= 1'b0;
    end
  end

  assign bus.tc_ready = link_running & (~bus.timec_en_to_tx | bus.timec_tx_ready);

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      bus.timec_tx_to_w  <= '0;
      bus.timec_en_to_tx <= 1'b0;
    end else if (!link_running) bus.timec_en_to_tx <= 1'b0;
    else if (bus.tc_valid && bus.tc_ready) begin
      bus.timec_tx_to_w  <= bus.tc_data;
      bus.timec_en_to_tx <= 1'b1;
    end else if (bus.timec_tx_ready) bus.timec_en_to_tx <= 1'b0;
  end
endmodule

// File: tb/tb_spw_tx_arbiter.sv
// Scoreboard bench for spw_tx_arbiter: source queues drive chars, expected TX chars are
// queued at stimulus time and popped as the TX core accepts them.
module tb_spw_tx_arbiter;
  logic clk, rst, link;
  int   cyc, n_chk, n_err;

  spw_tx_arbiter_if bus();
  spw_tx_arbiter #(.TIMEOUT(8)) dut (
    .clk_clk(clk), .reset_reset(rst), .link_running(link), .bus(bus)
  );

  initial begin clk = 1'b0; forever #5 clk = ~clk; end
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  logic [8:0] s0_q[$], s1_q[$], exp_q[$];
  logic [7:0] tc_q[$], tc_exp[$];
  int         acc_c[$];
  logic [1:0] acc_g[$];
  logic       fire0, fire1, tcfire, tog, mon_en, log_en, hold_v;
  logic [8:0] hold_d;
  int         f0_last, f0_n;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    logic [8:0] e;
    logic [7:0] te;
    fire0  = bus.src0_valid & bus.src0_ready;
    fire1  = bus.src1_valid & bus.src1_ready;
    tcfire = bus.tc_valid & bus.tc_ready;
    if (!rst && mon_en) begin
      if (bus.data_en_to_w && bus.data_tx_ready) begin
        if (log_en) begin acc_c.push_back(cyc); acc_g.push_back(bus.grant); end
        chk("tx_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin e = exp_q.pop_front(); chk("tx_data", bus.data_tx_to_w, e); end
      end
      if (hold_v && bus.data_en_to_w) chk("tx_hold", bus.data_tx_to_w, hold_d);
      if (bus.data_en_to_w && !bus.data_tx_ready)
        chk("rdy_busy", {bus.src1_ready, bus.src0_ready}, 0);
      chk("ungranted_rdy", {bus.src1_ready & ~bus.grant[1], bus.src0_ready & ~bus.grant[0]}, 0);
      if (bus.timec_en_to_tx && bus.timec_tx_ready) begin
        chk("tc_expected", 32'(tc_exp.size() != 0), 1);
        if (tc_exp.size() != 0) begin te = tc_exp.pop_front(); chk("tc_data", bus.timec_tx_to_w, te); end
      end
    end
    hold_v = bus.data_en_to_w & ~bus.data_tx_ready & ~rst;
    hold_d = bus.data_tx_to_w;
  end

  task automatic drive_src();
    bus.src0_valid = s0_q.size() != 0;
    bus.src0_data  = (s0_q.size() != 0) ? s0_q[0] : 9'h0;
    bus.src1_valid = s1_q.size() != 0;
    bus.src1_data  = (s1_q.size() != 0) ? s1_q[0] : 9'h0;
    bus.tc_valid   = tc_q.size() != 0;
    bus.tc_data    = (tc_q.size() != 0) ? tc_q[0] : 8'h0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    if (fire0 && s0_q.size() != 0) begin void'(s0_q.pop_front()); f0_last = cyc; f0_n++; end
    if (fire1 && s1_q.size() != 0) void'(s1_q.pop_front());
    if (tcfire && tc_q.size() != 0) void'(tc_q.pop_front());
    fire0 = 1'b0; fire1 = 1'b0; tcfire = 1'b0;
    if (tog) bus.data_tx_ready = ~bus.data_tx_ready;
    drive_src();
  endtask

  function automatic int pending();
    return s0_q.size() + s1_q.size() + exp_q.size() + tc_q.size() + tc_exp.size()
           + int'(bus.data_en_to_w) + int'(bus.timec_en_to_tx);
  endfunction

  task automatic drain(input string tag, input int max);
    for (int i = 0; i < max; i++) begin
      if (pending() == 0) break;
      tick();
    end
    chk(tag, pending(), 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_data"}, bus.data_tx_to_w, 0);
    chk({tag, "_en"}, bus.data_en_to_w, 0);
    chk({tag, "_tcdata"}, bus.timec_tx_to_w, 0);
    chk({tag, "_tcen"}, bus.timec_en_to_tx, 0);
    chk({tag, "_grant"}, bus.grant, 0);
    chk({tag, "_tpulse"}, bus.timeout_pulse, 0);
    chk({tag, "_apulse"}, bus.abort_pulse, 0);
  endtask

  initial begin
    int pcyc, base;
    cyc = 0; n_chk = 0; n_err = 0; f0_last = -1; f0_n = 0;
    fire0 = 0; fire1 = 0; tcfire = 0; tog = 0; mon_en = 0; log_en = 0; hold_v = 0; hold_d = 0;
    rst = 1'b1; link = 1'b1;
    bus.data_tx_ready = 1'b1; bus.timec_tx_ready = 1'b1;

    // Test 1: both sources valid from reset, round-robin with one gap cycle
    s0_q = '{9'h012, 9'h034, 9'h100};
    s1_q = '{9'h056, 9'h100};
    exp_q = '{9'h012, 9'h034, 9'h100, 9'h056, 9'h100};
    drive_src();
    repeat (3) tick();
    chk_reset_vals("reset");
    rst = 1'b0; mon_en = 1'b1; log_en = 1'b1;
    drain("t1_drain", 40);
    log_en = 1'b0;
    chk("t1_count", acc_c.size(), 5);
    if (acc_c.size() == 5) begin
      chk("t1_gap01", acc_c[1] - acc_c[0], 1);
      chk("t1_gap12", acc_c[2] - acc_c[1], 1);
      chk("t1_gap23", acc_c[3] - acc_c[2], 2);
      chk("t1_gap34", acc_c[4] - acc_c[3], 1);
      chk("t1_grant0", acc_g[0], 2'b01);
      chk("t1_grant1", acc_g[3], 2'b10);
    end

    // Test 2: TX ready toggling every cycle
    tog = 1'b1;
    s0_q = '{9'h001, 9'h002, 9'h003, 9'h004, 9'h100};
    exp_q = '{9'h001, 9'h002, 9'h003, 9'h004, 9'h100};
    drive_src();
    drain("t2_drain", 60);
    tog = 1'b0; bus.data_tx_ready = 1'b1;
    tick();

    // Test 3: stall timeout, EEP injection, rest of packet discarded
    f0_last = -1;
    s0_q = '{9'h011};
    exp_q = '{9'h011, 9'h101};
    drive_src();
    for (int i = 0; i < 20; i++) begin if (f0_last >= 0) break; tick(); end
    chk("t3_first_taken", 32'(f0_last >= 0), 1);
    pcyc = -1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.timeout_pulse) begin pcyc = cyc; break; end
    end
    chk("t3_latency", pcyc - f0_last, 8);
    chk("t3_eep_data", bus.data_tx_to_w, 9'h101);
    chk("t3_eep_en", bus.data_en_to_w, 1);
    tick();
    chk("t3_pulse_width", bus.timeout_pulse, 0);
    s0_q = '{9'h022, 9'h100};
    drive_src();
    drain("t3_drain", 30);
    tick();
    chk("t3_idle_grant", bus.grant, 0);

    // Test 4: link loss mid-packet with a char held on the output
    bus.data_tx_ready = 1'b0;
    s1_q = '{9'h041, 9'h042, 9'h043, 9'h100};
    drive_src();
    for (int i = 0; i < 10; i++) begin if (bus.data_en_to_w) break; tick(); end
    chk("t4_loaded", bus.data_en_to_w, 1);
    link = 1'b0;
    tick();
    chk("t4_en_cleared", bus.data_en_to_w, 0);
    chk("t4_abort", bus.abort_pulse, 1);
    tick();
    chk("t4_abort_width", bus.abort_pulse, 0);
    drain("t4_discard", 20);
    s0_q = '{9'h051, 9'h100};
    drive_src();
    repeat (5) begin
      tick();
      chk("t4_no_grant", bus.grant, 0);
    end
    link = 1'b1; bus.data_tx_ready = 1'b1;
    exp_q = '{9'h051, 9'h100};
    drain("t4_resume", 30);

    // Test 5: time code held while TX time-code side is busy; data path unaffected
    bus.timec_tx_ready = 1'b0;
    s0_q = '{9'h061, 9'h062, 9'h100};
    exp_q = '{9'h061, 9'h062, 9'h100};
    tc_q = '{8'h3F};
    tc_exp = '{8'h3F};
    drive_src();
    for (int i = 0; i < 10; i++) begin if (bus.timec_en_to_tx) break; tick(); end
    repeat (3) begin
      chk("t5_tc_en", bus.timec_en_to_tx, 1);
      chk("t5_tc_data", bus.timec_tx_to_w, 8'h3F);
      tick();
    end
    bus.timec_tx_ready = 1'b1;
    drain("t5_drain", 30);

    // Test 6: synchronous reset mid-packet, then src0 wins the next arbitration
    base = f0_n;
    s0_q = '{9'h071, 9'h072, 9'h073, 9'h100};
    exp_q = '{9'h071};
    drive_src();
    for (int i = 0; i < 10; i++) begin if (f0_n >= base + 2) break; tick(); end
    chk("t6_two_taken", f0_n - base, 2);
    chk("t6_first_sent", exp_q.size(), 0);
    rst = 1'b1; mon_en = 1'b0;
    s0_q.delete(); s1_q.delete(); exp_q.delete();
    drive_src();
    tick();
    chk_reset_vals("t6_reset");
    rst = 1'b0; mon_en = 1'b1;
    s0_q = '{9'h081, 9'h100};
    s1_q = '{9'h091, 9'h100};
    exp_q = '{9'h081, 9'h100, 9'h091, 9'h100};
    drive_src();
    for (int i = 0; i < 5; i++) begin tick(); if (bus.grant != 2'b00) break; end
    chk("t6_first_grant", bus.grant, 2'b01);
    drain("t6_drain", 40);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/spw_tx_arbiter.md
# spw_tx_arbiter

Packet-atomic round-robin arbiter sharing one SpaceWire ulight transmitter between two N-char sources, with an independent time-code channel. It sits between the host-side packet sources and the SpaceWire core's TX write interface (data_tx_to_w / data_en_to_w / data_tx_ready, timec_tx_to_w / timec_en_to_tx / timec_tx_ready). It also guarantees packet framing: it injects an EEP on source stall and discards the rest of a packet when the link drops.

## Interface
- TIMEOUT, 1024: cycles the granted source may hold valid low mid-packet before EEP injection (≥2).
- clk_clk  in  1  system clock; single clock domain.
- reset_reset  in  1  reset, synchronous, active-high.
- link_running  in  1  1 = SpaceWire FSM in Run state.
- src0_data / src1_data  in  9  N-char; bit8=1 marks a control char: 9'h100 = EOP, 9'h101 = EEP.
- src0_valid / src1_valid  in  1  source has a char.
- src0_ready / src1_ready  out  1  char consumed on this edge when valid&ready.
- tc_data  in  8  time code; tc_valid in 1; tc_ready out 1.
- data_tx_to_w  out  9  char to TX core.
- data_en_to_w  out  1  char valid toward TX core.
- data_tx_ready  in  1  TX core accepts when data_en_to_w&data_tx_ready.
- timec_tx_to_w  out  8; timec_en_to_tx out 1; timec_tx_ready in 1  time-code path, same handshake.
- grant  out  2  one-hot current owner; 2'b00 when idle.
- timeout_pulse  out  1  one-cycle pulse when an EEP is injected.
- abort_pulse  out  1  one-cycle pulse when link loss aborts a packet.

## Operation
- States: IDLE, PKT, INJECT, DISCARD.
- IDLE: grant=00. If link_running and any srcN_valid, grant the requester; when both request, grant the one not granted last. last_grant resets to src1, so src0 wins first. Next state PKT. No char is consumed in the grant cycle.
- PKT: srcN_ready = granted & (~data_en_to_w | data_tx_ready). An accepted char loads the output register and sets data_en_to_w. An accepted char with bit8=1 ends the packet: next state IDLE, last_grant updated.
- The output register holds until the TX core accepts it. data_en_to_w clears on acceptance unless it is reloaded in the same cycle.
- Stall counter: counts PKT cycles with granted valid low; cleared on any accepted char. When it reaches TIMEOUT and the output slot is free, load 9'h101, pulse timeout_pulse, go INJECT.
- INJECT: wait for EEP acceptance, then go DISCARD.
- DISCARD: granted srcN_ready=1 and chars are dropped, nothing goes to the TX core. After consuming a char with bit8=1, go IDLE and update last_grant.
- Link loss (link_running=0) in PKT or INJECT: clear data_en_to_w the same cycle, pulse abort_pulse, go DISCARD. Link loss in IDLE: no grant is issued.
- Time-code channel is independent of packet state:
  - tc_ready = link_running & (~timec_en_to_tx | timec_tx_ready).
  - Accepted tc_data loads timec_tx_to_w and sets timec_en_to_tx.
  - Link loss clears timec_en_to_tx.
- The ungranted source always sees ready=0.

## Timing
- All outputs are registered except srcN_ready and tc_ready, which are combinational from registered state and the ready inputs.
- Reset values: data_tx_to_w=0, data_en_to_w=0, timec_tx_to_w=0, timec_en_to_tx=0, grant=00, timeout_pulse=0, abort_pulse=0, state=IDLE, stall counter=0.
- Latency: a source char accepted at edge n appears on data_tx_to_w with data_en_to_w=1 after edge n.
- With data_tx_ready held at 1, throughput is 1 char/cycle (back-to-back via same-cycle reload).
- Packet switch overhead: 1 idle grant cycle after EOP/EEP acceptance.
- Timeout: EEP is loaded TIMEOUT cycles after the last accepted char, provided the output slot is free.
- Counter width: clog2(TIMEOUT+1); it saturates and does not wrap.
- Reset mid-packet: immediate return to reset values. No EEP is emitted. The partial packet is the source's responsibility.
- Simultaneous events:
  - Link loss and timeout in the same cycle: the abort takes precedence and no EEP is injected.
  - EOP acceptance and counter reaching TIMEOUT in the same cycle: the EOP wins.

## Test plan
- Both sources valid from reset, src0 packet {0x12,0x34,9'h100}, src1 packet {0x56,9'h100}, data_tx_ready=1 -> TX sees 0x12,0x34,0x100, one gap cycle, then 0x56,0x100; grant 01 then 10.
- data_tx_ready toggled 1/0 each cycle during a 5-char packet -> each char held stable until accepted; no loss or duplication; srcN_ready low while the output is occupied and not accepted.
- TIMEOUT=8, src0 sends 0x11 then drops valid -> 9'h101 loaded 8 cycles after 0x11 accepted, timeout_pulse=1 for one cycle; src0's later 0x22,9'h100 are consumed, not transmitted; then IDLE.
- link_running falls while src1 mid-packet with data_en_to_w=1 -> data_en_to_w=0 next cycle, abort_pulse one cycle; src1 chars drained until its EOP; no grant while the link is down.
- tc_valid with tc_data=0x3F during a src0 packet, timec_tx_ready=0 for 3 cycles -> timec_tx_to_w=0x3F held with timec_en_to_tx=1 until accept; data path is unaffected.
- Synchronous reset asserted mid-packet -> all outputs return to reset values the next cycle; the next arbitration favours src0.
